// File: rtl/asic_readout_sequencer.sv
// Readout sequencer for the ASIC daisy chain.
// Frames deserialized RAM words into the external FIFO.
module asic_readout_sequencer #(
    parameter logic [15:0] HEADER_WORD    = 16'hFFF0,
    parameter logic [15:0] TRAILER_WORD   = 16'hFFF1,
    parameter logic [3:0]  START_LEN      = 4'd4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
    parameter logic [7:0]  DRAIN_CYCLES   = 8'd160
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        ReadoutStart,
    input  logic        EndReadout,
    input  logic [15:0] asic_data,
    input  logic        asic_data_en,
    input  logic        ext_fifo_full,
    output logic        StartReadout,
    output logic [15:0] fifo_data,
    output logic        fifo_wr_en,
    output logic        ReadoutBusy,
    output logic        ReadoutDone,
    output logic        TimeoutFlag,
    output logic        OverflowFlag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_START,
        S_READ,
        S_DRAIN,
        S_COUNT,
        S_TRAILER,
        S_DONE
    } state_t;

    localparam logic [23:0] START_LAST = 24'(START_LEN) - 24'd1;
    localparam logic [23:0] TMO_LAST   = TIMEOUT_CYCLES - 24'd1;
    localparam logic [23:0] DRAIN_LAST = 24'(DRAIN_CYCLES) - 24'd1;

    state_t      state;
    state_t      state_nx;
    logic        sync1;
    logic        sync2;
    logic        sync2_d;
    logic        end_rise;
    logic [23:0] cnt;
    logic        cnt_clr;
    logic [13:0] word_cnt;
    logic        fwd_state;
    logic        accept;
    logic        drop;
    logic        frm_wr;
    logic [15:0] frm_data;
    logic        tmo_set;

    assign end_rise  = sync2 & ~sync2_d;
    assign fwd_state = (state == S_START) |
                       (state == S_READ)  |
                       (state == S_DRAIN);
    assign accept    = asic_data_en & fwd_state & ~ext_fifo_full;
    assign drop      = asic_data_en & fwd_state & ext_fifo_full;

    assign StartReadout = (state == S_START);
    assign ReadoutBusy  = (state != S_IDLE);
    assign ReadoutDone  = (state == S_DONE);

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= EndReadout;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and framing-word selection
    always_comb begin
        state_nx = state;
        frm_wr   = 1'b0;
        frm_data = 16'h0000;
        tmo_set  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ReadoutStart) state_nx = S_HEADER;
            end
            S_HEADER: begin
                if (!ext_fifo_full) begin
                    frm_wr   = 1'b1;
                    frm_data = HEADER_WORD;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (cnt == START_LAST) state_nx = S_READ;
            end
            S_READ: begin
                if (end_rise) begin
                    state_nx = S_DRAIN;
                end else if (cnt == TMO_LAST) begin
                    tmo_set  = 1'b1;
                    state_nx = S_COUNT;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) state_nx = S_COUNT;
            end
            S_COUNT: begin
                if (!ext_fifo_full) begin
                    frm_wr   = 1'b1;
                    frm_data = {OverflowFlag, TimeoutFlag, word_cnt};
                    state_nx = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (!ext_fifo_full) begin
                    frm_wr   = 1'b1;
                    frm_data = TRAILER_WORD;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign cnt_clr = (state_nx != state);

    // Per-state cycle counter, cleared on every state change
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            cnt <= 24'd0;
        end else if (cnt_clr) begin
            cnt <= 24'd0;
        end else if (cnt != 24'hFFFFFF) begin
            cnt <= cnt + 24'd1;
        end
    end

    // FIFO write port, word count and sticky frame flags
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_data    <= 16'h0000;
            word_cnt     <= 14'd0;
            TimeoutFlag  <= 1'b0;
            OverflowFlag <= 1'b0;
        end else begin
            fifo_wr_en <= accept | frm_wr;
            if (accept) begin
                fifo_data <= asic_data;
            end else if (frm_wr) begin
                fifo_data <= frm_data;
            end
            if (state == S_IDLE && ReadoutStart) begin
                word_cnt     <= 14'd0;
                TimeoutFlag  <= 1'b0;
                OverflowFlag <= 1'b0;
            end else begin
                if (accept && word_cnt != 14'h3FFF) begin
                    word_cnt <= word_cnt + 14'd1;
                end
                if (drop) OverflowFlag <= 1'b1;
                if (tmo_set) TimeoutFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_asic_readout_sequencer.sv
// Randomized self-checking bench for asic_readout_sequencer.
// Frames are predicted from the word schedule the bench drives.
`timescale 1ns/1ps
module tb_asic_readout_sequencer;

    localparam int TMO = 1000;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ReadoutStart = 1'b0;
    logic        EndReadout = 1'b0;
    logic [15:0] asic_data = 16'h0;
    logic        asic_data_en = 1'b0;
    logic        ext_fifo_full = 1'b0;
    logic        StartReadout;
    logic [15:0] fifo_data;
    logic        fifo_wr_en;
    logic        ReadoutBusy;
    logic        ReadoutDone;
    logic        TimeoutFlag;
    logic        OverflowFlag;

    asic_readout_sequencer #(
        .TIMEOUT_CYCLES(24'd1000)
    ) dut (
        .Clk(Clk),
        .reset_n(reset_n),
        .ReadoutStart(ReadoutStart),
        .EndReadout(EndReadout),
        .asic_data(asic_data),
        .asic_data_en(asic_data_en),
        .ext_fifo_full(ext_fifo_full),
        .StartReadout(StartReadout),
        .fifo_data(fifo_data),
        .fifo_wr_en(fifo_wr_en),
        .ReadoutBusy(ReadoutBusy),
        .ReadoutDone(ReadoutDone),
        .TimeoutFlag(TimeoutFlag),
        .OverflowFlag(OverflowFlag)
    );

    always #12 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] got[$];
    int          s_cyc[$];
    logic [15:0] s_dat[$];
    bit          s_full[$];
    bit          last_ovf;

    // FIFO capture
    always @(negedge Clk) begin
        if (reset_n && fifo_wr_en) got.push_back(fifo_data);
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sched_clear();
        s_cyc.delete();
        s_dat.delete();
        s_full.delete();
    endtask

    task automatic add_word(input int c, input logic [15:0] d,
                            input bit f);
        s_cyc.push_back(c);
        s_dat.push_back(d);
        s_full.push_back(f);
    endtask

    task automatic sched_random(input int nw, input int pct);
        int c = 0;
        sched_clear();
        for (int i = 0; i < nw; i++) begin
            c += $urandom_range(1, 4);
            add_word(c, 16'($urandom), $urandom_range(0, 99) < pct);
        end
    endtask

    function automatic int sched_last();
        return (s_cyc.size() > 0) ? s_cyc[s_cyc.size()-1] : 0;
    endfunction

    // Runs one frame; k = READ cycle EndReadout rises (-1: never)
    task automatic run_frame(input int k, input int stall);
        logic [15:0] exp[$];
        int  base;
        int  cnt = 0;
        bit  ovf = 0;
        bit  tmo;
        int  hi = 0;
        int  g = 0;
        int  p = 0;
        bit  done = 0;
        bit  any_start = 0;
        tmo = (k < 0) || (k > TMO - 3);
        exp.push_back(16'hFFF0);
        for (int i = 0; i < s_cyc.size(); i++) begin
            if (s_full[i]) begin
                ovf = 1;
            end else begin
                exp.push_back(s_dat[i]);
                if (cnt < 16383) cnt++;
            end
        end
        exp.push_back({ovf, tmo, 14'(cnt)});
        exp.push_back(16'hFFF1);
        last_ovf = ovf;
        base = got.size();
        if (stall > 0) ext_fifo_full = 1'b1;
        ReadoutStart = 1'b1;
        @(negedge Clk);
        ReadoutStart = 1'b0;
        check("flags_clr", {ReadoutBusy, TimeoutFlag, OverflowFlag},
              3'b100);
        if (stall > 0) begin
            repeat (stall) begin
                any_start |= StartReadout;
                @(negedge Clk);
            end
            check("stall_start", any_start, 0);
            check("stall_wr", got.size() - base, 0);
            ext_fifo_full = 1'b0;
        end
        while (!StartReadout && g < 100) begin
            g++;
            @(negedge Clk);
        end
        while (StartReadout && hi < 100) begin
            hi++;
            @(negedge Clk);
        end
        check("start_len", hi, 4);
        for (int r = 0; r < 3000 && !done; r++) begin
            if (ReadoutDone) begin
                done = 1;
            end else begin
                asic_data_en  = 1'b0;
                ext_fifo_full = 1'b0;
                if (p < s_cyc.size() && s_cyc[p] == r) begin
                    asic_data_en  = 1'b1;
                    asic_data     = s_dat[p];
                    ext_fifo_full = s_full[p];
                    p++;
                end
                ReadoutStart = (r == 2);
                if (k >= 0 && r >= k) EndReadout = 1'b1;
                @(negedge Clk);
            end
        end
        check("done_seen", done, 1);
        asic_data_en  = 1'b0;
        ext_fifo_full = 1'b0;
        ReadoutStart  = 1'b0;
        EndReadout    = 1'b0;
        check("tmo_flag", TimeoutFlag, tmo);
        check("ovf_flag", OverflowFlag, ovf);
        @(negedge Clk);
        check("done_pulse", {ReadoutDone, ReadoutBusy}, 0);
        check("frame_len", got.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size())
                check("frame_word", got[base+i], exp[i]);
        end
    endtask

    // Words offered while idle must be ignored
    task automatic idle_words();
        int base = got.size();
        repeat (4) begin
            asic_data_en  = 1'b1;
            asic_data     = 16'($urandom);
            ext_fifo_full = 1'($urandom);
            @(negedge Clk);
        end
        asic_data_en  = 1'b0;
        ext_fifo_full = 1'b0;
        @(negedge Clk);
        check("idle_wr", got.size() - base, 0);
        check("idle_ovf", {ReadoutBusy, OverflowFlag}, {1'b0, last_ovf});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int g;
        repeat (3) @(negedge Clk);
        check("rst_out", {StartReadout, fifo_wr_en, ReadoutBusy,
                          ReadoutDone, TimeoutFlag, OverflowFlag}, 0);
        check("rst_data", fifo_data, 0);
        reset_n = 1'b1;
        @(negedge Clk);

        sched_clear();
        add_word(1, 16'h1234, 0);
        add_word(3, 16'hABCD, 0);
        add_word(4, 16'h0001, 0);
        run_frame(10, 0);

        sched_clear();
        run_frame(-1, 0);

        sched_clear();
        add_word(1, 16'hAAAA, 0);
        add_word(3, 16'hBBBB, 1);
        add_word(5, 16'hCCCC, 0);
        run_frame(9, 0);
        idle_words();

        sched_random(4, 0);
        run_frame(sched_last() + 3, 50);

        sched_random(5, 20);
        run_frame(TMO - 3, 0);
        sched_random(5, 20);
        run_frame(TMO - 2, 0);

        for (int n = 0; n < 6; n++) begin
            sched_random($urandom_range(0, 20), 25);
            if ($urandom_range(0, 3) == 0) begin
                run_frame(-1, 0);
            end else begin
                k = sched_last() + $urandom_range(1, 6);
                add_word(k + 3 + $urandom_range(2, 20), 16'($urandom),
                         1'($urandom_range(0, 1)));
                run_frame(k, 0);
            end
            idle_words();
        end

        ReadoutStart = 1'b1;
        @(negedge Clk);
        ReadoutStart = 1'b0;
        g = 0;
        while (!StartReadout && g < 100) begin
            g++;
            @(negedge Clk);
        end
        while (StartReadout && g < 200) begin
            g++;
            @(negedge Clk);
        end
        for (int r = 0; r < 6; r++) begin
            asic_data_en  = (r == 1) || (r == 3) || (r == 4);
            ext_fifo_full = (r == 3);
            asic_data     = 16'($urandom);
            if (r == 5) check("pre_rst_ovf", OverflowFlag, 1);
            if (r == 5) reset_n = 1'b0;
            @(negedge Clk);
        end
        asic_data_en  = 1'b0;
        ext_fifo_full = 1'b0;
        check("mid_rst", {StartReadout, fifo_wr_en, ReadoutBusy,
                          ReadoutDone, TimeoutFlag, OverflowFlag}, 0);
        reset_n = 1'b1;
        @(negedge Clk);
        sched_random(3, 0);
        run_frame(sched_last() + 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
